// File: rtl/ualink_dpram_pkg.sv
// Shared constants for the ualink true dual-port RAM: read-during-write modes,
// clear-sweep state encoding and collision counter helpers.
package ualink_dpram_pkg;

    localparam logic [1:0] RDW_WRITE_FIRST = 2'd0;
    localparam logic [1:0] RDW_READ_FIRST  = 2'd1;
    localparam logic [1:0] RDW_NO_CHANGE   = 2'd2;

    localparam int COLL_CNT_W = 16;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } dpram_state_e;

    // Saturating increment so a long collision burst never wraps to a small count.
    function automatic logic [COLL_CNT_W-1:0] sat_inc(input logic [COLL_CNT_W-1:0] v);
        logic [COLL_CNT_W-1:0] r;
        if (v == 16'hFFFF) begin
            r = v;
        end else begin
            r = v + 16'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/ualink_dpram_port.sv
// One access port of the ualink dual-port RAM: byte merge, read-during-write
// selection and the dout/dval output stage (second stage under UALINK_DPRAM_OUTREG_EN).
module ualink_dpram_port
    import ualink_dpram_pkg::*;
#(
    parameter int         DATA_WIDTH = 64,
    parameter logic [1:0] RDW_MODE   = 2'd0
) (
    input  logic                    axi_aclk,
    input  logic                    axi_resetn,
    input  logic                    en,
    input  logic                    we,
    input  logic [DATA_WIDTH/8-1:0] be,
    input  logic                    oor,
    input  logic [DATA_WIDTH-1:0]   din,
    input  logic [DATA_WIDTH-1:0]   old_word,
    input  logic [DATA_WIDTH-1:0]   new_word,
    output logic                    wr,
    output logic [DATA_WIDTH-1:0]   merged,
    output logic [DATA_WIDTH-1:0]   dout,
    output logic                    dval
);

    localparam int NB = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] dout_s1_r;
    logic                  dval_s1_r;

    // A write with no byte lanes enabled behaves as a plain read.
    assign wr = en & we & (|be) & ~oor;

    // Overlay this port's enabled bytes onto the current word.
    always_comb begin
        merged = old_word;
        for (int i = 0; i < NB; i++) begin
            if (be[i]) begin
                merged[8*i +: 8] = din[8*i +: 8];
            end else begin
                merged[8*i +: 8] = old_word[8*i +: 8];
            end
        end
    end

    // First output stage: one-cycle read latency with read-during-write selection.
    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            dout_s1_r <= {DATA_WIDTH{1'b0}};
            dval_s1_r <= 1'b0;
        end else if (!en) begin
            dval_s1_r <= 1'b0;
        end else if (oor) begin
            dout_s1_r <= {DATA_WIDTH{1'b0}};
            dval_s1_r <= 1'b1;
        end else if (wr) begin
            case (RDW_MODE)
                RDW_WRITE_FIRST: begin
                    dout_s1_r <= new_word;
                    dval_s1_r <= 1'b1;
                end
                RDW_READ_FIRST: begin
                    dout_s1_r <= old_word;
                    dval_s1_r <= 1'b1;
                end
                RDW_NO_CHANGE: begin
                    dval_s1_r <= 1'b0;
                end
                default: begin
                    dval_s1_r <= 1'b0;
                end
            endcase
        end else begin
            dout_s1_r <= old_word;
            dval_s1_r <= 1'b1;
        end
    end

`ifdef UALINK_DPRAM_OUTREG_EN
    logic [DATA_WIDTH-1:0] dout_s2_r;
    logic                  dval_s2_r;

    // Second output stage; data only moves with a valid so dout still holds between reads.
    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            dout_s2_r <= {DATA_WIDTH{1'b0}};
            dval_s2_r <= 1'b0;
        end else begin
            dval_s2_r <= dval_s1_r;
            if (dval_s1_r) begin
                dout_s2_r <= dout_s1_r;
            end
        end
    end

    assign dout = dout_s2_r;
    assign dval = dval_s2_r;
`else
    assign dout = dout_s1_r;
    assign dval = dval_s1_r;
`endif

endmodule

// File: rtl/ualink_dpram_tdp.sv
// ualink true dual-port RAM: storage array, post-reset clear sweep, cross-port
// collision priority and error/collision counters. UALINK_DPRAM_OUTREG_EN adds an output stage.
module ualink_dpram_tdp
    import ualink_dpram_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    DATA_WIDTH = 64,
    parameter int                    DEPTH      = 1 << ADDR_WIDTH,
    parameter logic [1:0]            RDW_MODE   = 2'd0,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = {DATA_WIDTH{1'b0}}
) (
    input  logic                    axi_aclk,
    input  logic                    axi_resetn,
    input  logic                    en_a,
    input  logic                    we_a,
    input  logic [DATA_WIDTH/8-1:0] be_a,
    input  logic [ADDR_WIDTH-1:0]   addr_a,
    input  logic [DATA_WIDTH-1:0]   din_a,
    output logic [DATA_WIDTH-1:0]   dout_a,
    output logic                    dval_a,
    input  logic                    en_b,
    input  logic                    we_b,
    input  logic [DATA_WIDTH/8-1:0] be_b,
    input  logic [ADDR_WIDTH-1:0]   addr_b,
    input  logic [DATA_WIDTH-1:0]   din_b,
    output logic [DATA_WIDTH-1:0]   dout_b,
    output logic                    dval_b,
    output logic                    init_done,
    output logic                    collision,
    output logic [COLL_CNT_W-1:0]   coll_cnt,
    output logic                    oor_err
);

    localparam int                    NB       = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH:0]   DEPTH_X  = DEPTH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    dpram_state_e          state_r;
    logic [ADDR_WIDTH-1:0] ptr_r;
    logic                  init_done_r;
    logic                  coll_r;
    logic [COLL_CNT_W-1:0] coll_cnt_r;
    logic                  oor_err_r;

    logic                  acc_a_s, acc_b_s, oor_a_s, oor_b_s, wr_a_s, wr_b_s;
    logic                  both_wr_s, coll_s;
    logic [DATA_WIDTH-1:0] old_a_s, old_b_s, merged_a_s, merged_b_s;
    logic [DATA_WIDTH-1:0] comb_s, word_a_s, word_b_s;

    assign acc_a_s = en_a & init_done_r;
    assign acc_b_s = en_b & init_done_r;
    assign oor_a_s = ({1'b0, addr_a} >= DEPTH_X);
    assign oor_b_s = ({1'b0, addr_b} >= DEPTH_X);

    // Current contents seen by each port; out-of-range addresses never index the array.
    always_comb begin
        old_a_s = {DATA_WIDTH{1'b0}};
        old_b_s = {DATA_WIDTH{1'b0}};
        if (!oor_a_s) begin
            old_a_s = mem[addr_a];
        end else begin
            old_a_s = {DATA_WIDTH{1'b0}};
        end
        if (!oor_b_s) begin
            old_b_s = mem[addr_b];
        end else begin
            old_b_s = {DATA_WIDTH{1'b0}};
        end
    end

    // Same-address double write: A owns its enabled bytes, B fills the rest it enables.
    always_comb begin
        comb_s = merged_b_s;
        for (int i = 0; i < NB; i++) begin
            if (be_a[i]) begin
                comb_s[8*i +: 8] = din_a[8*i +: 8];
            end else begin
                comb_s[8*i +: 8] = merged_b_s[8*i +: 8];
            end
        end
    end

    assign both_wr_s = wr_a_s & wr_b_s & (addr_a == addr_b);
    assign word_a_s  = both_wr_s ? comb_s : merged_a_s;
    assign word_b_s  = both_wr_s ? comb_s : merged_b_s;
    assign coll_s    = acc_a_s & acc_b_s & (addr_a == addr_b) & (wr_a_s | wr_b_s);

    ualink_dpram_port #(.DATA_WIDTH(DATA_WIDTH), .RDW_MODE(RDW_MODE)) u_port_a (
        .axi_aclk   (axi_aclk),
        .axi_resetn (axi_resetn),
        .en         (acc_a_s),
        .we         (we_a),
        .be         (be_a),
        .oor        (oor_a_s),
        .din        (din_a),
        .old_word   (old_a_s),
        .new_word   (word_a_s),
        .wr         (wr_a_s),
        .merged     (merged_a_s),
        .dout       (dout_a),
        .dval       (dval_a)
    );

    ualink_dpram_port #(.DATA_WIDTH(DATA_WIDTH), .RDW_MODE(RDW_MODE)) u_port_b (
        .axi_aclk   (axi_aclk),
        .axi_resetn (axi_resetn),
        .en         (acc_b_s),
        .we         (we_b),
        .be         (be_b),
        .oor        (oor_b_s),
        .din        (din_b),
        .old_word   (old_b_s),
        .new_word   (word_b_s),
        .wr         (wr_b_s),
        .merged     (merged_b_s),
        .dout       (dout_b),
        .dval       (dval_b)
    );

    // Clear-sweep FSM: one word per cycle, then RUN until the next reset.
    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            state_r     <= ST_INIT;
            ptr_r       <= {ADDR_WIDTH{1'b0}};
            init_done_r <= 1'b0;
        end else begin
            case (state_r)
                ST_INIT: begin
                    if (ptr_r == LAST_PTR) begin
                        state_r     <= ST_RUN;
                        init_done_r <= 1'b1;
                    end else begin
                        ptr_r <= ptr_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                    end
                end
                ST_RUN: begin
                    init_done_r <= 1'b1;
                end
                default: begin
                    state_r     <= ST_INIT;
                    ptr_r       <= {ADDR_WIDTH{1'b0}};
                    init_done_r <= 1'b0;
                end
            endcase
        end
    end

    // Storage array; contents are only ever initialised by the sweep.
    always_ff @(posedge axi_aclk) begin
        if (state_r == ST_INIT) begin
            mem[ptr_r] <= INIT_VALUE;
        end else begin
            if (wr_a_s) begin
                mem[addr_a] <= word_a_s;
            end
            if (wr_b_s) begin
                mem[addr_b] <= word_b_s;
            end
        end
    end

    // Collision pulse, saturating collision count and sticky out-of-range flag.
    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            coll_r     <= 1'b0;
            coll_cnt_r <= 16'd0;
            oor_err_r  <= 1'b0;
        end else begin
            coll_r    <= coll_s;
            oor_err_r <= oor_err_r | (acc_a_s & oor_a_s) | (acc_b_s & oor_b_s);
            if (coll_s) begin
                coll_cnt_r <= sat_inc(coll_cnt_r);
            end
        end
    end

`ifdef UALINK_DPRAM_OUTREG_EN
    logic coll_s2_r;

    // Align the collision pulse with the delayed read data.
    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            coll_s2_r <= 1'b0;
        end else begin
            coll_s2_r <= coll_r;
        end
    end

    assign collision = coll_s2_r;
`else
    assign collision = coll_r;
`endif

    assign init_done = init_done_r;
    assign coll_cnt  = coll_cnt_r;
    assign oor_err   = oor_err_r;

endmodule

// File: tb/tb_ualink_dpram_tdp.sv
// Table-driven bench for ualink_dpram_tdp: three instances (RDW 0/1/2, one with DEPTH=200)
// share stimulus; port-A enable of instances 1 and 2 is gated for isolated sequences.
module tb_ualink_dpram_tdp;

`ifdef UALINK_DPRAM_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    localparam logic [63:0] K5A = 64'h5A5A5A5A5A5A5A5A;
    localparam logic [63:0] KAA = 64'hAAAAAAAAAAAAAAAA;
    localparam logic [63:0] KBB = 64'hBBBBBBBBBBBBBBBB;
    localparam logic [63:0] KAB = 64'hAAAAAAAABBBBBBBB;
    localparam logic [63:0] K12 = 64'h1122334455667788;
    localparam logic [63:0] K1A = 64'h11223344AAAAAAAA;
    localparam logic [63:0] K01 = 64'h0123456789ABCDEF;
    localparam logic [63:0] KFF = 64'hFFFFFFFFFFFFFFFF;
    localparam logic [63:0] KF5 = 64'hFF5A5A5A5A5A5AFF;
    localparam logic [63:0] KDE = 64'hDEADBEEFCAFEF00D;

    typedef struct {
        logic        en_a, we_a;
        logic [7:0]  be_a, addr_a;
        logic [63:0] din_a;
        logic        en_b, we_b;
        logic [7:0]  be_b, addr_b;
        logic [63:0] din_b;
        logic        va;
        logic [63:0] da;
        logic        vb;
        logic [63:0] db;
        logic        coll;
        logic [15:0] cnt;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en_a = 1'b0, we_a = 1'b0, en_b = 1'b0, we_b = 1'b0;
    logic [7:0]  be_a = 8'h00, be_b = 8'h00, addr_a = 8'h00, addr_b = 8'h00;
    logic [63:0] din_a = 64'h0, din_b = 64'h0;
    logic [2:0]  sel = 3'b001;
    logic [2:0]  en_a_i, en_b_i;

    logic [63:0] dout_a_o [3];
    logic [63:0] dout_b_o [3];
    logic [15:0] cnt_o [3];
    logic [2:0]  dval_a_o, dval_b_o, done_o, coll_o, oor_o;

    int passed = 0;
    int total  = 0;

    assign en_a_i = {3{en_a}} & sel;
    assign en_b_i = {3{en_b}} & sel;

    always #5 clk = ~clk;

    for (genvar k = 0; k < 3; k++) begin : g_dut
        ualink_dpram_tdp #(
            .ADDR_WIDTH (8),
            .DATA_WIDTH (64),
            .DEPTH      ((k == 1) ? 200 : 256),
            .RDW_MODE   (2'(k)),
            .INIT_VALUE (K5A)
        ) u_dut (
            .axi_aclk   (clk),
            .axi_resetn (rst_n),
            .en_a       (en_a_i[k]),
            .we_a       (we_a),
            .be_a       (be_a),
            .addr_a     (addr_a),
            .din_a      (din_a),
            .dout_a     (dout_a_o[k]),
            .dval_a     (dval_a_o[k]),
            .en_b       (en_b_i[k]),
            .we_b       (we_b),
            .be_b       (be_b),
            .addr_b     (addr_b),
            .din_b      (din_b),
            .dout_b     (dout_b_o[k]),
            .dval_b     (dval_b_o[k]),
            .init_done  (done_o[k]),
            .collision  (coll_o[k]),
            .coll_cnt   (cnt_o[k]),
            .oor_err    (oor_o[k])
        );
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end else begin
            passed++;
        end
    endtask

    // Drive one access for a cycle, idle afterwards, and wait until its result is visible.
    task automatic run_io(input logic ea, input logic wa, input logic [7:0] bea, input logic [7:0] aa,
                          input logic [63:0] da, input logic eb, input logic wb, input logic [7:0] beb,
                          input logic [7:0] ab, input logic [63:0] db);
        en_a = ea; we_a = wa; be_a = bea; addr_a = aa; din_a = da;
        en_b = eb; we_b = wb; be_b = beb; addr_b = ab; din_b = db;
        @(negedge clk);
        en_a = 1'b0; we_a = 1'b0; en_b = 1'b0; we_b = 1'b0;
        repeat (LAT - 1) @(negedge clk);
    endtask

    // Count cycles from reset release to init_done for instances 0 and 1, holding en_a on.
    task automatic wait_init(input logic hold_en, output int n0, output int n1, output logic saw);
        int n;
        n = 0; n0 = -1; n1 = -1; saw = 1'b0;
        en_a = hold_en; we_a = 1'b0; addr_a = 8'h00;
        while ((n0 < 0 || n1 < 0) && n < 2000) begin
            @(negedge clk);
            n++;
            if (dval_a_o[0]) saw = 1'b1;
            if (done_o[0] && n0 < 0) begin
                n0 = n;
                en_a = 1'b0;
            end
            if (done_o[1] && n1 < 0) n1 = n;
        end
        en_a = 1'b0;
    endtask

    vec_t vecs [12];
    int   n0, n1;
    logic saw;

    initial begin
        vecs[0]  = '{1'b1,1'b0,8'h00,8'h00,64'h0, 1'b1,1'b0,8'h00,8'hFF,64'h0, 1'b1,K5A, 1'b1,K5A, 1'b0,16'd0};
        vecs[1]  = '{1'b1,1'b1,8'hFF,8'h10,K12,   1'b0,1'b0,8'h00,8'h00,64'h0, 1'b1,K12, 1'b0,K5A, 1'b0,16'd0};
        vecs[2]  = '{1'b1,1'b1,8'h0F,8'h10,KAA,   1'b0,1'b0,8'h00,8'h00,64'h0, 1'b1,K1A, 1'b0,K5A, 1'b0,16'd0};
        vecs[3]  = '{1'b1,1'b0,8'h00,8'h10,64'h0, 1'b1,1'b0,8'h00,8'h10,64'h0, 1'b1,K1A, 1'b1,K1A, 1'b0,16'd0};
        vecs[4]  = '{1'b1,1'b1,8'hF0,8'h30,KAA,   1'b1,1'b1,8'hFF,8'h30,KBB,   1'b1,KAB, 1'b1,KAB, 1'b1,16'd1};
        vecs[5]  = '{1'b1,1'b0,8'h00,8'h30,64'h0, 1'b0,1'b0,8'h00,8'h00,64'h0, 1'b1,KAB, 1'b0,KAB, 1'b0,16'd1};
        vecs[6]  = '{1'b1,1'b0,8'h00,8'h30,64'h0, 1'b1,1'b1,8'hFF,8'h30,K01,   1'b1,KAB, 1'b1,K01, 1'b1,16'd2};
        vecs[7]  = '{1'b1,1'b0,8'h00,8'h30,64'h0, 1'b0,1'b0,8'h00,8'h00,64'h0, 1'b1,K01, 1'b0,K01, 1'b0,16'd2};
        vecs[8]  = '{1'b1,1'b0,8'h00,8'h40,64'h0, 1'b1,1'b1,8'h00,8'h40,KFF,   1'b1,K5A, 1'b1,K5A, 1'b0,16'd2};
        vecs[9]  = '{1'b0,1'b0,8'h00,8'h00,64'h0, 1'b0,1'b0,8'h00,8'h00,64'h0, 1'b0,K5A, 1'b0,K5A, 1'b0,16'd2};
        vecs[10] = '{1'b1,1'b1,8'h81,8'h41,KFF,   1'b0,1'b0,8'h00,8'h00,64'h0, 1'b1,KF5, 1'b0,K5A, 1'b0,16'd2};
        vecs[11] = '{1'b0,1'b0,8'h00,8'h00,64'h0, 1'b1,1'b0,8'h00,8'h41,64'h0, 1'b0,KF5, 1'b1,KF5, 1'b0,16'd2};

        // Reset values
        @(negedge clk);
        chk("rst_dout_a", dout_a_o[0], 64'h0);
        chk("rst_dval_a", {63'h0, dval_a_o[0]}, 64'h0);
        chk("rst_init_done", {61'h0, done_o}, 64'h0);
        chk("rst_collision", {63'h0, coll_o[0]}, 64'h0);
        chk("rst_coll_cnt", {48'h0, cnt_o[0]}, 64'h0);
        chk("rst_oor_err", {63'h0, oor_o[0]}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Clear sweep, with port A requesting throughout
        wait_init(1'b1, n0, n1, saw);
        chk("init_cycles_256", 64'(n0), 64'd256);
        chk("init_cycles_200", 64'(n1), 64'd200);
        chk("dval_during_init", {63'h0, saw}, 64'h0);
        @(negedge clk);

        // Directed vector table on instance 0
        for (int i = 0; i < 12; i++) begin
            run_io(vecs[i].en_a, vecs[i].we_a, vecs[i].be_a, vecs[i].addr_a, vecs[i].din_a,
                   vecs[i].en_b, vecs[i].we_b, vecs[i].be_b, vecs[i].addr_b, vecs[i].din_b);
            chk($sformatf("v%0d_dval_a", i), {63'h0, dval_a_o[0]}, {63'h0, vecs[i].va});
            chk($sformatf("v%0d_dout_a", i), dout_a_o[0], vecs[i].da);
            chk($sformatf("v%0d_dval_b", i), {63'h0, dval_b_o[0]}, {63'h0, vecs[i].vb});
            chk($sformatf("v%0d_dout_b", i), dout_b_o[0], vecs[i].db);
            chk($sformatf("v%0d_collision", i), {63'h0, coll_o[0]}, {63'h0, vecs[i].coll});
            chk($sformatf("v%0d_coll_cnt", i), {48'h0, cnt_o[0]}, {48'h0, vecs[i].cnt});
        end

        // Read-during-write modes on all three instances
        sel = 3'b111;
        run_io(1'b1, 1'b1, 8'hFF, 8'h20, 64'h1, 1'b0, 1'b0, 8'h00, 8'h00, 64'h0);
        chk("rdw1_first_old", dout_a_o[1], K5A);
        chk("rdw2_first_dval", {63'h0, dval_a_o[2]}, 64'h0);
        run_io(1'b1, 1'b1, 8'hFF, 8'h20, 64'h2, 1'b0, 1'b0, 8'h00, 8'h00, 64'h0);
        chk("rdw0_dout", dout_a_o[0], 64'h2);
        chk("rdw1_dout", dout_a_o[1], 64'h1);
        chk("rdw1_dval", {63'h0, dval_a_o[1]}, 64'h1);
        chk("rdw2_dval", {63'h0, dval_a_o[2]}, 64'h0);
        chk("rdw2_dout_held", dout_a_o[2], 64'h0);
        run_io(1'b1, 1'b0, 8'h00, 8'h20, 64'h0, 1'b0, 1'b0, 8'h00, 8'h00, 64'h0);
        chk("rdw1_readback", dout_a_o[1], 64'h2);
        chk("rdw2_readback", dout_a_o[2], 64'h2);

        // Out-of-range access on the DEPTH=200 instance
        chk("oor_err_before", {63'h0, oor_o[1]}, 64'h0);
        run_io(1'b1, 1'b1, 8'hFF, 8'hC8, KDE, 1'b0, 1'b0, 8'h00, 8'h00, 64'h0);
        chk("oor_wr_dout", dout_a_o[1], 64'h0);
        chk("oor_wr_dval", {63'h0, dval_a_o[1]}, 64'h1);
        chk("oor_err_set", {63'h0, oor_o[1]}, 64'h1);
        chk("inrange_no_oor", {63'h0, oor_o[0]}, 64'h0);
        run_io(1'b1, 1'b0, 8'h00, 8'hC7, 64'h0, 1'b1, 1'b0, 8'h00, 8'hC8, 64'h0);
        chk("oor_rd_dout", dout_b_o[1], 64'h0);
        chk("oor_rd_dval", {63'h0, dval_b_o[1]}, 64'h1);
        chk("last_word_intact", dout_a_o[1], K5A);
        chk("inrange_rd_c8", dout_b_o[0], KDE);
        repeat (5) @(negedge clk);
        chk("oor_err_sticky", {63'h0, oor_o[1]}, 64'h1);
        sel = 3'b001;

        // Reset mid-sweep restarts the clear from address 0
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_oor_clr", {63'h0, oor_o[1]}, 64'h0);
        chk("midrst_cnt_clr", {48'h0, cnt_o[0]}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_init(1'b0, n0, n1, saw);
        chk("reinit_cycles_256", 64'(n0), 64'd256);
        chk("reinit_cycles_200", 64'(n1), 64'd200);
        run_io(1'b1, 1'b0, 8'h00, 8'h10, 64'h0, 1'b1, 1'b0, 8'h00, 8'h30, 64'h0);
        chk("reinit_rd_10", dout_a_o[0], K5A);
        chk("reinit_rd_30", dout_b_o[0], K5A);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
